// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the pedestrian crossing request logic.
package traffic_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPending = 2'd1,
        StWalk    = 2'd2,
        StFlash   = 2'd3
    } cross_state_e;

    localparam int unsigned DefaultDebounceTicks = 16;
    localparam int unsigned DefaultWalkTicks     = 8;
    localparam int unsigned DefaultFlashTicks    = 4;
    localparam int unsigned DefaultMaxWaitTicks  = 64;

endpackage

// File: rtl/crossing_request_arbiter_if.sv
// Button/sequencer handshake bundle between the light sequencer and the crossing arbiter.
interface crossing_request_arbiter_if;

    logic [3:0] btn;
    logic       take_ns;
    logic       take_ew;
    logic       ns_pending;
    logic       ew_pending;
    logic       ns_walk;
    logic       ew_walk;
    logic       ns_flash;
    logic       ew_flash;
    logic       ns_hurry;
    logic       ew_hurry;

    modport master (
        output btn, take_ns, take_ew,
        input  ns_pending, ew_pending, ns_walk, ew_walk,
        input  ns_flash, ew_flash, ns_hurry, ew_hurry
    );

    modport slave (
        input  btn, take_ns, take_ew,
        output ns_pending, ew_pending, ns_walk, ew_walk,
        output ns_flash, ew_flash, ns_hurry, ew_hurry
    );

endinterface

// File: rtl/cross_channel.sv
// One crossing direction: request FSM, walk/flash timers, rearm bit and optional hurry timeout.
// Optional timeout logic is built only when CROSS_TIMEOUT_EN is defined.
module cross_channel
    import traffic_pkg::*;
#(
    parameter int unsigned WALK_TICKS     = DefaultWalkTicks,
    parameter int unsigned FLASH_TICKS    = DefaultFlashTicks,
    parameter int unsigned MAX_WAIT_TICKS = DefaultMaxWaitTicks
) (
    input  logic slowclk,
    input  logic reset,
    input  logic i_press,
    input  logic i_take,
    output logic o_pending,
    output logic o_walk,
    output logic o_flash,
    output logic o_hurry
);

    localparam int unsigned WalkW  = $clog2(WALK_TICKS + 1);
    localparam int unsigned FlashW = $clog2(FLASH_TICKS + 1);

    if (WALK_TICKS < 1 || FLASH_TICKS < 1 || MAX_WAIT_TICKS < 1) begin : g_param_check
        $error("cross_channel: tick parameters must be at least 1");
    end

    cross_state_e            r_state, w_state_d;
    logic [WalkW-1:0]        r_walk_cnt, w_walk_cnt_d;
    logic [FlashW-1:0]       r_flash_cnt, w_flash_cnt_d;
    logic                    r_rearm, w_rearm_d;
    logic                    r_pending, r_walk, r_flash;

    always_comb begin
        w_state_d     = r_state;
        w_walk_cnt_d  = r_walk_cnt;
        w_flash_cnt_d = r_flash_cnt;
        w_rearm_d     = r_rearm;
        case (r_state)
            StIdle: begin
                if (i_press) begin
                    w_state_d = StPending;
                end
            end
            StPending: begin
                // A press coinciding with take is absorbed by the service it requested.
                if (i_take) begin
                    w_state_d    = StWalk;
                    w_walk_cnt_d = WalkW'(WALK_TICKS - 1);
                end
            end
            StWalk: begin
                w_rearm_d = r_rearm | i_press;
                if (r_walk_cnt == '0) begin
                    w_state_d     = StFlash;
                    w_flash_cnt_d = FlashW'(FLASH_TICKS - 1);
                end else begin
                    w_walk_cnt_d = r_walk_cnt - 1'b1;
                end
            end
            StFlash: begin
                w_rearm_d = r_rearm | i_press;
                if (r_flash_cnt == '0) begin
                    w_state_d = (r_rearm | i_press) ? StPending : StIdle;
                    w_rearm_d = 1'b0;
                end else begin
                    w_flash_cnt_d = r_flash_cnt - 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_walk_cnt  <= '0;
            r_flash_cnt <= '0;
            r_rearm     <= 1'b0;
            r_pending   <= 1'b0;
            r_walk      <= 1'b0;
            r_flash     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_walk_cnt  <= w_walk_cnt_d;
            r_flash_cnt <= w_flash_cnt_d;
            r_rearm     <= w_rearm_d;
            r_pending   <= (w_state_d == StPending);
            r_walk      <= (w_state_d == StWalk);
            r_flash     <= (w_state_d == StFlash);
        end
    end

    assign o_pending = r_pending;
    assign o_walk    = r_walk;
    assign o_flash   = r_flash;

`ifdef CROSS_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(MAX_WAIT_TICKS + 1);

    logic [WaitW-1:0] r_wait, w_wait_d;
    logic             r_hurry;

    // Wait count restarts at zero on every entry to pending and saturates at the limit.
    always_comb begin
        w_wait_d = '0;
        if (w_state_d == StPending && r_state == StPending) begin
            if (r_wait != WaitW'(MAX_WAIT_TICKS)) begin
                w_wait_d = r_wait + 1'b1;
            end else begin
                w_wait_d = r_wait;
            end
        end
    end

    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            r_wait  <= '0;
            r_hurry <= 1'b0;
        end else begin
            r_wait  <= w_wait_d;
            r_hurry <= (w_state_d == StPending) && (w_wait_d == WaitW'(MAX_WAIT_TICKS));
        end
    end

    assign o_hurry = r_hurry;
`else
    assign o_hurry = 1'b0;
`endif

endmodule

// File: rtl/crossing_request_arbiter.sv
// Pedestrian crossing request arbiter: button synchronise/debounce plus one channel per direction.
// Define CROSS_TIMEOUT_EN to build the pending-wait hurry timeout.
module crossing_request_arbiter
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DefaultDebounceTicks,
    parameter int unsigned WALK_TICKS     = DefaultWalkTicks,
    parameter int unsigned FLASH_TICKS    = DefaultFlashTicks,
    parameter int unsigned MAX_WAIT_TICKS = DefaultMaxWaitTicks
) (
    input  logic                       slowclk,
    input  logic                       reset,
    crossing_request_arbiter_if.slave  io_bus
);

    localparam int unsigned DebW = $clog2(DEBOUNCE_TICKS + 1);

    if (DEBOUNCE_TICKS < 1) begin : g_param_check
        $error("crossing_request_arbiter: DEBOUNCE_TICKS must be at least 1");
    end

    logic [3:0]      r_meta;
    logic [3:0]      r_sync;
    logic [DebW-1:0] r_run [4];
    logic [3:0]      r_press;
    logic            w_press_ns;
    logic            w_press_ew;

    // Press fires on the sample that brings the run to DEBOUNCE_TICKS; saturation stops repeats.
    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            r_meta  <= '0;
            r_sync  <= '0;
            r_press <= '0;
            for (int i = 0; i < 4; i++) begin
                r_run[i] <= '0;
            end
        end else begin
            r_meta <= io_bus.btn;
            r_sync <= r_meta;
            for (int i = 0; i < 4; i++) begin
                if (!r_sync[i]) begin
                    r_run[i] <= '0;
                end else if (r_run[i] != DebW'(DEBOUNCE_TICKS)) begin
                    r_run[i] <= r_run[i] + 1'b1;
                end
                r_press[i] <= r_sync[i] && (r_run[i] == DebW'(DEBOUNCE_TICKS - 1));
            end
        end
    end

    assign w_press_ns = r_press[1] | r_press[3];
    assign w_press_ew = r_press[0] | r_press[2];

    cross_channel #(
        .WALK_TICKS     (WALK_TICKS),
        .FLASH_TICKS    (FLASH_TICKS),
        .MAX_WAIT_TICKS (MAX_WAIT_TICKS)
    ) u_ns (
        .slowclk   (slowclk),
        .reset     (reset),
        .i_press   (w_press_ns),
        .i_take    (io_bus.take_ns),
        .o_pending (io_bus.ns_pending),
        .o_walk    (io_bus.ns_walk),
        .o_flash   (io_bus.ns_flash),
        .o_hurry   (io_bus.ns_hurry)
    );

    cross_channel #(
        .WALK_TICKS     (WALK_TICKS),
        .FLASH_TICKS    (FLASH_TICKS),
        .MAX_WAIT_TICKS (MAX_WAIT_TICKS)
    ) u_ew (
        .slowclk   (slowclk),
        .reset     (reset),
        .i_press   (w_press_ew),
        .i_take    (io_bus.take_ew),
        .o_pending (io_bus.ew_pending),
        .o_walk    (io_bus.ew_walk),
        .o_flash   (io_bus.ew_flash),
        .o_hurry   (io_bus.ew_hurry)
    );

endmodule
